// File: rtl/arbitro_somador_subtrator_pkg.sv
// rtl/arbitro_somador_subtrator_pkg.sv - shared opcodes and FSM encodings for the add/sub arbiter
package arbitro_somador_subtrator_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/arbitro_somador_subtrator_if.sv
// rtl/arbitro_somador_subtrator_if.sv - two request channels, one tagged response channel and the op counter
interface arbitro_somador_subtrator_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);

  logic             req0_valid;
  logic             req0_ready;
  logic             req0_op;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic             req1_op;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH:0]   rsp_result;
  logic [CNT_W-1:0] ops_done;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_result, ops_done
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_result, ops_done
  );

endinterface

// File: rtl/somador_e_subtrator.sv
// rtl/somador_e_subtrator.sv - combinational datapath: s1 = a+b with carry, s2 = a-b with borrow/sign
module somador_e_subtrator #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH:0]   s1,
  output logic [WIDTH:0]   s2
);

  assign s1 = {1'b0, a} + {1'b0, b};
  assign s2 = {1'b0, a} - {1'b0, b};

endmodule

// File: rtl/arbitro_somador_subtrator.sv
// rtl/arbitro_somador_subtrator.sv - round-robin arbiter sharing one add/sub datapath between two requesters
module arbitro_somador_subtrator
  import arbitro_somador_subtrator_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input logic                        clk,
  input logic                        rst_n,
  arbitro_somador_subtrator_if.slave bus
);

  state_t           state;
  logic             ptr;
  logic             op_q;
  logic             id_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   s1;
  logic [WIDTH:0]   s2;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH:0]   rsp_result_q;
  logic [CNT_W-1:0] ops_done_q;
  logic             any_valid;
  logic             grant_id;

  // A lone requester wins outright; the pointer only breaks ties.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    grant_id  = (bus.req0_valid && bus.req1_valid) ? ptr : bus.req1_valid;
  end

  // Gated by rst_n so ready reads low while reset is asserted.
  assign bus.req0_ready = rst_n && (state == ST_IDLE) && any_valid && !grant_id;
  assign bus.req1_ready = rst_n && (state == ST_IDLE) && any_valid && grant_id;

  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.ops_done   = ops_done_q;

  somador_e_subtrator #(.WIDTH(WIDTH)) u_datapath (
    .a  (a_q),
    .b  (b_q),
    .s1 (s1),
    .s2 (s2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ptr          <= 1'b0;
      op_q         <= OP_ADD;
      id_q         <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      ops_done_q   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            id_q  <= grant_id;
            ptr   <= ~grant_id;
            op_q  <= grant_id ? bus.req1_op : bus.req0_op;
            a_q   <= grant_id ? bus.req1_a  : bus.req0_a;
            b_q   <= grant_id ? bus.req1_b  : bus.req0_b;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          rsp_result_q <= (op_q == OP_SUB) ? s2 : s1;
          rsp_id_q     <= id_q;
          rsp_valid_q  <= 1'b1;
          state        <= ST_RESP;
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            ops_done_q  <= ops_done_q + CNT_W'(1);
            state       <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arbitro_somador_subtrator.sv
// tb/tb_arbitro_somador_subtrator.sv - directed vectors with a response scoreboard; counter built 2 bits wide to exercise wrap
module tb_arbitro_somador_subtrator;

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
  } req_t;

  typedef struct {
    logic       id;
    logic [8:0] res;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  req_t rq0[$];
  req_t rq1[$];
  exp_t exp_q[$];
  int   acc_q[$];

  arbitro_somador_subtrator_if #(.WIDTH(8), .CNT_W(2)) bus ();

  arbitro_somador_subtrator #(.WIDTH(8), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Requester 0 driver: presents queued ops, drops valid after acceptance.
  initial begin : drv0
    req_t r;
    logic done = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    forever begin
      @(negedge clk);
      if (done) begin bus.req0_valid = 1'b0; done = 1'b0; end
      if (!bus.req0_valid && rq0.size() > 0) begin
        r = rq0.pop_front();
        bus.req0_op = r.op; bus.req0_a = r.a; bus.req0_b = r.b; bus.req0_valid = 1'b1;
      end
      #1;
      if (bus.req0_valid && bus.req0_ready) begin acc_q.push_back(cyc); done = 1'b1; end
    end
  end

  initial begin : drv1
    req_t r;
    logic done = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_op = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    forever begin
      @(negedge clk);
      if (done) begin bus.req1_valid = 1'b0; done = 1'b0; end
      if (!bus.req1_valid && rq1.size() > 0) begin
        r = rq1.pop_front();
        bus.req1_op = r.op; bus.req1_a = r.a; bus.req1_b = r.b; bus.req1_valid = 1'b1;
      end
      #1;
      if (bus.req1_valid && bus.req1_ready) begin acc_q.push_back(cyc); done = 1'b1; end
    end
  end

  // Monitor: pops expected responses on each handshake and tracks the op counter.
  logic       prev_valid = 1'b0;
  logic       chk_done = 1'b0;
  logic       held_id;
  logic [8:0] held_res;
  int         model_done = 0;

  always @(negedge clk) begin
    exp_t e;
    #3;
    if (!rst_n) begin
      model_done = 0; prev_valid = 1'b0; chk_done = 1'b0;
    end else begin
      if (chk_done) begin
        check("ops_done", 32'(bus.ops_done), 32'(model_done));
        chk_done = 1'b0;
      end
      if (bus.rsp_valid) begin
        if (!prev_valid) begin
          if (acc_q.size() > 0) check("latency", 32'(cyc - acc_q.pop_front()), 32'd2);
          else check("latency_accept_seen", 32'd0, 32'd1);
        end else begin
          check("hold_id", 32'(bus.rsp_id), 32'(held_id));
          check("hold_result", 32'(bus.rsp_result), 32'(held_res));
        end
        check("ready_low_busy", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
        held_id  = bus.rsp_id;
        held_res = bus.rsp_result;
        if (bus.rsp_ready) begin
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rsp_id", 32'(bus.rsp_id), 32'(e.id));
            check("rsp_result", 32'(bus.rsp_result), 32'(e.res));
          end else begin
            check("unexpected_rsp", 32'(bus.rsp_result), 32'h1ff_ffff);
          end
          model_done = (model_done + 1) % 4;
          chk_done = 1'b1;
        end
      end
      prev_valid = bus.rsp_valid && !bus.rsp_ready;
    end
  end

  task automatic push_req(input int who, input logic op, input logic [7:0] a, input logic [7:0] b);
    req_t r;
    r.op = op; r.a = a; r.b = b;
    if (who == 0) rq0.push_back(r); else rq1.push_back(r);
  endtask

  task automatic push_exp(input logic id, input logic [8:0] res);
    exp_t e;
    e.id = id; e.res = res;
    exp_q.push_back(e);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk); #2;
      n++;
    end
    check(name, 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    #2;
  endtask

  initial begin : main
    int n;
    rst_n = 1'b0;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    // Reset values
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("rst_rsp_result", 32'(bus.rsp_result), 32'd0);
    check("rst_ops_done", 32'(bus.ops_done), 32'd0);
    check("rst_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk); #2;
    check("idle_ready", 32'({bus.req0_ready, bus.req1_ready}), 32'd0);
    check("idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);

    // Single add from requester 0
    bus.rsp_ready = 1'b1;
    push_exp(1'b0, 9'd10);
    push_req(0, 1'b0, 8'd5, 8'd5);
    wait_drain("t2_drain");
    check("t2_ops_done", 32'(bus.ops_done), 32'd1);

    // Both valid from reset: alternation 0,1,0,1 then lone 0; five ops wrap the 2-bit counter to 1
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #2;
    push_exp(1'b0, 9'h1FB);
    push_exp(1'b1, 9'h1FE);
    push_exp(1'b0, 9'h003);
    push_exp(1'b1, 9'h1FF);
    push_exp(1'b0, 9'h100);
    push_req(0, 1'b1, 8'd5,   8'd10);
    push_req(0, 1'b0, 8'd1,   8'd2);
    push_req(0, 1'b0, 8'h80,  8'h80);
    push_req(1, 1'b0, 8'd255, 8'd255);
    push_req(1, 1'b1, 8'd0,   8'd1);
    wait_drain("t3_drain");
    check("t3_ops_wrap", 32'(bus.ops_done), 32'd1);

    // Back-pressure with requester 1 waiting
    bus.rsp_ready = 1'b0;
    push_exp(1'b0, 9'd2);
    push_exp(1'b1, 9'd7);
    push_req(0, 1'b0, 8'd1, 8'd1);
    n = 0;
    while (!bus.rsp_valid && n < 50) begin @(negedge clk); #2; n++; end
    check("t4_rsp_seen", 32'(bus.rsp_valid), 32'd1);
    push_req(1, 1'b0, 8'd3, 8'd4);
    repeat (10) begin
      @(negedge clk); #2;
      check("t4_req1_ready", 32'(bus.req1_ready), 32'd0);
      check("t4_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    end
    bus.rsp_ready = 1'b1;
    wait_drain("t4_drain");
    check("t4_ops_done", 32'(bus.ops_done), 32'd3);

    // Reset during CALC discards the op and restores the pointer to requester 0
    push_req(0, 1'b0, 8'd9, 8'd9);
    n = 0;
    while (acc_q.size() == 0 && n < 50) begin @(negedge clk); #2; n++; end
    check("t5_accepted", 32'(acc_q.size()), 32'd1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    acc_q.delete();
    repeat (3) begin
      @(negedge clk); #2;
      check("t5_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check("t5_ops_done", 32'(bus.ops_done), 32'd0);
    end
    rst_n = 1'b1;
    push_exp(1'b0, 9'd2);
    push_exp(1'b1, 9'd4);
    push_req(0, 1'b0, 8'd1, 8'd1);
    push_req(1, 1'b0, 8'd2, 8'd2);
    wait_drain("t5_drain");
    check("t5_ops_after", 32'(bus.ops_done), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
